// File: rtl/mdu_pkg.sv
// Shared definitions for the multi-cycle multiply/divide unit: op codes,
// FSM state encoding and small elaboration-time helpers.
package mdu_pkg;

    localparam logic [2:0] MDU_MULT  = 3'd0;
    localparam logic [2:0] MDU_MULTU = 3'd1;
    localparam logic [2:0] MDU_DIV   = 3'd2;
    localparam logic [2:0] MDU_DIVU  = 3'd3;
    localparam logic [2:0] MDU_MADD  = 3'd4;
    localparam logic [2:0] MDU_MADDU = 3'd5;
    localparam logic [2:0] MDU_MSUB  = 3'd6;
    localparam logic [2:0] MDU_MSUBU = 3'd7;

    typedef enum logic {
        MDU_IDLE = 1'b0,
        MDU_BUSY = 1'b1
    } mdu_state_t;

    function automatic int mdu_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Bits needed to hold values 0..value-1; never less than one bit.
    function automatic int mdu_clog2(input int value);
        int bits;
        int v;
        bits = 0;
        v    = value - 1;
        while (v > 0) begin
            bits = bits + 1;
            v    = v >> 1;
        end
        return (bits < 1) ? 1 : bits;
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational arithmetic core: signed/unsigned multiply, multiply-accumulate
// and multiply-subtract against {hi,lo}, and signed/unsigned divide.
module mdu_arith
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] phi,
    output logic [WIDTH-1:0] plo,
    output logic             is_div,
    output logic             dz
);

    logic [2*WIDTH-1:0]        uprod;
    logic signed [2*WIDTH-1:0] sprod;
    logic [2*WIDTH-1:0]        prod;
    logic [2*WIDTH-1:0]        acc;
    logic [2*WIDTH-1:0]        result;

    logic                      div_zero;
    logic [WIDTH-1:0]          udivisor;
    logic [WIDTH-1:0]          uquot;
    logic [WIDTH-1:0]          urem;

    logic                      a_neg;
    logic                      b_neg;
    logic [WIDTH-1:0]          a_mag;
    logic [WIDTH-1:0]          b_mag;
    logic [WIDTH-1:0]          mquot;
    logic [WIDTH-1:0]          mrem;
    logic [WIDTH-1:0]          squot;
    logic [WIDTH-1:0]          srem;

    assign uprod = {{WIDTH{1'b0}}, in1} * {{WIDTH{1'b0}}, in2};
    assign sprod = $signed({{WIDTH{in1[WIDTH-1]}}, in1}) * $signed({{WIDTH{in2[WIDTH-1]}}, in2});
    // Odd op codes are the unsigned flavours of every multiply-class op.
    assign prod  = op[0] ? uprod : $unsigned(sprod);
    assign acc   = {hi, lo};

    // Divisor forced to 1 when zero so the dividers never produce X; the
    // result is discarded in that case anyway.
    assign div_zero = (in2 == '0);
    assign udivisor = div_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : in2;
    assign uquot    = in1 / udivisor;
    assign urem     = in1 % udivisor;

    // Signed divide via magnitudes; most-negative / -1 falls out naturally
    // as quotient most-negative, remainder 0.
    assign a_neg = in1[WIDTH-1];
    assign b_neg = in2[WIDTH-1];
    assign a_mag = a_neg ? (~in1 + 1'b1) : in1;
    assign b_mag = div_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : (b_neg ? (~in2 + 1'b1) : in2);
    assign mquot = a_mag / b_mag;
    assign mrem  = a_mag % b_mag;
    assign squot = (a_neg ^ b_neg) ? (~mquot + 1'b1) : mquot;
    assign srem  = a_neg ? (~mrem + 1'b1) : mrem;

    always_comb begin
        result = acc;
        case (op)
            MDU_MULT, MDU_MULTU: result = prod;
            MDU_MADD, MDU_MADDU: result = acc + prod;
            MDU_MSUB, MDU_MSUBU: result = acc - prod;
            MDU_DIV:             result = {srem, squot};
            MDU_DIVU:            result = {urem, uquot};
            default:             result = acc;
        endcase
    end

    assign is_div = (op == MDU_DIV) || (op == MDU_DIVU);
    assign dz     = is_div && div_zero;
    assign phi    = result[2*WIDTH-1:WIDTH];
    assign plo    = result[WIDTH-1:0];

endmodule

// File: rtl/mdu_multicycle.sv
// Multi-cycle multiply/divide unit owning HI/LO. Define MDU_FLUSH_EN to add
// a flush input that aborts an in-flight operation without committing.
module mdu_multicycle
    import mdu_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic             clk,
    input  logic             reset,
`ifdef MDU_FLUSH_EN
    input  logic             flush,
`endif
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             hiwe,
    input  logic             lowe,
    output logic             busy,
    output logic             done,
    output logic             div0,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = mdu_clog2(mdu_max(MUL_CYCLES, DIV_CYCLES));
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    mdu_state_t       state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [WIDTH-1:0] hi_reg;
    logic [WIDTH-1:0] lo_reg;
    logic [WIDTH-1:0] phi_reg;
    logic [WIDTH-1:0] plo_reg;
    logic             dz_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             div0_reg;

    logic [WIDTH-1:0] arith_hi;
    logic [WIDTH-1:0] arith_lo;
    logic             arith_is_div;
    logic             arith_dz;

    mdu_arith #(
        .WIDTH (WIDTH)
    ) u_arith (
        .op     (op),
        .in1    (in1),
        .in2    (in2),
        .hi     (hi_reg),
        .lo     (lo_reg),
        .phi    (arith_hi),
        .plo    (arith_lo),
        .is_div (arith_is_div),
        .dz     (arith_dz)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= MDU_IDLE;
            cnt_reg   <= '0;
            hi_reg    <= '0;
            lo_reg    <= '0;
            phi_reg   <= '0;
            plo_reg   <= '0;
            dz_reg    <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            div0_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            div0_reg <= 1'b0;
`ifdef MDU_FLUSH_EN
            // Flush wins over launch, MTHI/MTLO and the commit edge alike.
            if (flush) begin
                state_reg <= MDU_IDLE;
                cnt_reg   <= '0;
                phi_reg   <= '0;
                plo_reg   <= '0;
                dz_reg    <= 1'b0;
                busy_reg  <= 1'b0;
            end else
`endif
            case (state_reg)
                MDU_IDLE: begin
                    if (start) begin
                        // Result is captured at launch; operands may change afterwards.
                        phi_reg   <= arith_hi;
                        plo_reg   <= arith_lo;
                        dz_reg    <= arith_dz;
                        cnt_reg   <= arith_is_div ? DIV_LOAD : MUL_LOAD;
                        busy_reg  <= 1'b1;
                        state_reg <= MDU_BUSY;
                    end else begin
                        if (hiwe) hi_reg <= in1;
                        if (lowe) lo_reg <= in1;
                    end
                end
                MDU_BUSY: begin
                    if (cnt_reg == '0) begin
                        if (!dz_reg) begin
                            hi_reg <= phi_reg;
                            lo_reg <= plo_reg;
                        end
                        done_reg  <= 1'b1;
                        div0_reg  <= dz_reg;
                        busy_reg  <= 1'b0;
                        state_reg <= MDU_IDLE;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                default: begin
                    state_reg <= MDU_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;
    assign div0 = div0_reg;
    assign hi   = hi_reg;
    assign lo   = lo_reg;

endmodule

// File: tb/tb_mdu_multicycle.sv
// Self-checking bench for mdu_multicycle: directed cases plus random ops
// checked against an arithmetic reference model of HI/LO.
module tb_mdu_multicycle;

    localparam int W   = 32;
    localparam int MUL = 5;
    localparam int DIV = 10;

    logic         clk;
    logic         reset;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] in1;
    logic [W-1:0] in2;
    logic         hiwe;
    logic         lowe;
    logic         busy;
    logic         done;
    logic         div0;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
`ifdef MDU_FLUSH_EN
    logic         flush;
`endif

    int checks;
    int failures;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    mdu_multicycle #(
        .WIDTH      (W),
        .MUL_CYCLES (MUL),
        .DIV_CYCLES (DIV)
    ) dut (
        .clk   (clk),
        .reset (reset),
`ifdef MDU_FLUSH_EN
        .flush (flush),
`endif
        .start (start),
        .op    (op),
        .in1   (in1),
        .in2   (in2),
        .hiwe  (hiwe),
        .lowe  (lowe),
        .busy  (busy),
        .done  (done),
        .div0  (div0),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Architectural reference: plain integer arithmetic on the op semantics.
    function automatic void ref_model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                      input logic [31:0] h, input logic [31:0] l,
                                      output logic [31:0] nh, output logic [31:0] nl, output logic dz);
        logic [63:0] acc;
        logic [63:0] sp;
        logic [63:0] up;
        int sa;
        int sb;
        acc = {h, l};
        sp  = 64'(longint'($signed(a)) * longint'($signed(b)));
        up  = {32'b0, a} * {32'b0, b};
        nh  = h;
        nl  = l;
        dz  = 1'b0;
        sa  = $signed(a);
        sb  = $signed(b);
        case (o)
            3'd0: {nh, nl} = sp;
            3'd1: {nh, nl} = up;
            3'd2: begin
                if (b == 0) dz = 1'b1;
                else if (a == 32'h8000_0000 && sb == -1) begin
                    nl = 32'h8000_0000;
                    nh = 32'h0;
                end else begin
                    nl = sa / sb;
                    nh = sa % sb;
                end
            end
            3'd3: begin
                if (b == 0) dz = 1'b1;
                else begin
                    nl = a / b;
                    nh = a % b;
                end
            end
            3'd4: {nh, nl} = acc + sp;
            3'd5: {nh, nl} = acc + up;
            3'd6: {nh, nl} = acc - sp;
            default: {nh, nl} = acc - up;
        endcase
    endfunction

    // Called on a falling edge; returns on the falling edge after launch.
    task automatic launch(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        op    = o;
        in1   = a;
        in2   = b;
        @(negedge clk);
        start = 1'b0;
        in1   = $urandom;
        in2   = $urandom;
        chk("launch_busy", {63'b0, busy}, 64'd1);
        chk("launch_done_low", {63'b0, done}, 64'd0);
    endtask

    task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input bit disturb);
        logic [31:0] eh;
        logic [31:0] el;
        logic        edz;
        int          n;
        int          cnt;
        int          k;
        ref_model(o, a, b, m_hi, m_lo, eh, el, edz);
        n = (o == 3'd2 || o == 3'd3) ? DIV : MUL;
        launch(o, a, b);
        cnt = 0;
        k   = 0;
        while (!done && k < 100) begin
            if (busy) cnt++;
            if (disturb && k == 2) begin
                start = 1'b1;
                hiwe  = 1'b1;
                lowe  = 1'b1;
                op    = 3'($urandom_range(0, 7));
                in1   = $urandom;
            end else if (disturb && k == 3) begin
                start = 1'b0;
                hiwe  = 1'b0;
                lowe  = 1'b0;
            end
            @(negedge clk);
            k++;
        end
        chk("done_seen", {63'b0, done}, 64'd1);
        chk("busy_cycles", 64'(cnt), 64'(n));
        chk("hi", {32'b0, hi}, {32'b0, eh});
        chk("lo", {32'b0, lo}, {32'b0, el});
        chk("div0", {63'b0, div0}, {63'b0, edz});
        chk("busy_after", {63'b0, busy}, 64'd0);
        if (!edz) begin
            m_hi = eh;
            m_lo = el;
        end
        $display("op=%0d in1=%08h in2=%08h -> hi=%08h lo=%08h div0=%0d busy_cycles=%0d", o, a, b, hi, lo, div0, cnt);
    endtask

    task automatic mt(input bit hw, input bit lw, input logic [31:0] v);
        hiwe = hw;
        lowe = lw;
        in1  = v;
        @(negedge clk);
        hiwe = 1'b0;
        lowe = 1'b0;
        if (hw) m_hi = v;
        if (lw) m_lo = v;
        chk("mt_hi", {32'b0, hi}, {32'b0, m_hi});
        chk("mt_lo", {32'b0, lo}, {32'b0, m_lo});
        $display("mt hiwe=%0d lowe=%0d val=%08h -> hi=%08h lo=%08h", hw, lw, v, hi, lo);
    endtask

    initial begin
        logic [2:0]  ro;
        logic [31:0] rb;
        checks   = 0;
        failures = 0;
        m_hi     = 32'h0;
        m_lo     = 32'h0;
        reset    = 1'b0;
        start    = 1'b0;
        op       = 3'd0;
        in1      = '0;
        in2      = '0;
        hiwe     = 1'b0;
        lowe     = 1'b0;
`ifdef MDU_FLUSH_EN
        flush    = 1'b0;
`endif
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy", {63'b0, busy}, 64'd0);
        chk("rst_done", {63'b0, done}, 64'd0);
        chk("rst_div0", {63'b0, div0}, 64'd0);
        chk("rst_hilo", {hi, lo}, 64'd0);
        reset = 1'b1;
        @(negedge clk);

        // Directed cases.
        do_op(3'd0, 32'hFFFF_FFFF, 32'd2, 1'b0);
        chk("mult_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFE);
        do_op(3'd1, 32'hFFFF_FFFF, 32'd2, 1'b0);
        chk("multu_const", {hi, lo}, 64'h0000_0001_FFFF_FFFE);
        do_op(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
        chk("div_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        chk("div_ovf_const", {hi, lo}, 64'h0000_0000_8000_0000);
        mt(1'b1, 1'b0, 32'h0);
        mt(1'b0, 1'b1, 32'hFFFF_FFFF);
        do_op(3'd5, 32'd1, 32'd1, 1'b0);
        chk("maddu_const", {hi, lo}, 64'h0000_0001_0000_0000);
        mt(1'b1, 1'b1, 32'h0);
        do_op(3'd6, 32'd1, 32'd1, 1'b0);
        chk("msub_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFF);
        mt(1'b1, 1'b0, 32'h12);
        mt(1'b0, 1'b1, 32'h34);
        do_op(3'd3, 32'd5, 32'd0, 1'b0);
        chk("divu0_const", {hi, lo}, 64'h0000_0012_0000_0034);
        do_op(3'd0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
        do_op(3'd3, 32'hDEAD_BEEF, 32'h0000_1234, 1'b1);

        // Random back-to-back traffic with occasional MTHI/MTLO.
        for (int i = 0; i < 24; i++) begin
            ro = 3'($urandom_range(0, 7));
            rb = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            if ($urandom_range(0, 5) == 0) mt($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom);
            do_op(ro, $urandom, rb, $urandom_range(0, 4) == 0);
        end

        // Asynchronous reset in the middle of a multiply.
        mt(1'b1, 1'b1, 32'hA5A5_A5A5);
        launch(3'd0, 32'h7, 32'h9);
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("midrst_busy", {63'b0, busy}, 64'd0);
        chk("midrst_hilo", {hi, lo}, 64'd0);
        chk("midrst_done", {63'b0, done}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        m_hi  = 32'h0;
        m_lo  = 32'h0;
        for (int i = 0; i < MUL + 2; i++) begin
            @(negedge clk);
            chk("midrst_no_done", {63'b0, done}, 64'd0);
        end
        chk("midrst_hilo_hold", {hi, lo}, 64'd0);
        $display("reset mid-op -> busy=%0d hi=%08h lo=%08h", busy, hi, lo);

`ifdef MDU_FLUSH_EN
        mt(1'b1, 1'b1, 32'h5555_AAAA);
        launch(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", {63'b0, busy}, 64'd0);
        chk("flush_done", {63'b0, done}, 64'd0);
        chk("flush_hilo", {hi, lo}, {m_hi, m_lo});
        start = 1'b1;
        hiwe  = 1'b1;
        flush = 1'b1;
        in1   = 32'h1;
        @(negedge clk);
        start = 1'b0;
        hiwe  = 1'b0;
        flush = 1'b0;
        chk("flush_idle_busy", {63'b0, busy}, 64'd0);
        chk("flush_idle_hi", {32'b0, hi}, {32'b0, m_hi});
        $display("flush mid-op -> busy=%0d hi=%08h lo=%08h", busy, hi, lo);
        do_op(3'd4, 32'd3, 32'd4, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mdu_multicycle.md
Name: mdu_multicycle

Overview:
- Parametrised multiply/divide unit for the execute stage. Generalises the fixed 32-bit MDU in operand width and per-class latency, and adds multiply-accumulate/subtract and divide-by-zero reporting.
- Owns the HI/LO architectural registers.
- Reports busy to hazard control, which stalls any HI/LO-dependent instruction behind it.

Parameters:
- WIDTH, 32, operand width and HI/LO width.
- MUL_CYCLES, 5, busy cycles for multiply-class ops (must be >=1).
- DIV_CYCLES, 10, busy cycles for divide-class ops (must be >=1).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous active-low reset; asserted when 0.
- start  input  1  one-cycle launch strobe.
- op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MADD, 5 MADDU, 6 MSUB, 7 MSUBU.
- in1  input  WIDTH  rs operand / dividend.
- in2  input  WIDTH  rt operand / divisor.
- hiwe  input  1  MTHI write enable; writes in1 to HI.
- lowe  input  1  MTLO write enable; writes in1 to LO.
- busy  output  1  operation in flight.
- done  output  1  one-cycle pulse on the commit cycle.
- div0  output  1  one-cycle pulse, concurrent with done, when a divide had divisor 0.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset: state IDLE; counter 0. busy, done and div0 are 0. hi and lo are 0; pending result registers are 0.
- FSM states: IDLE and BUSY.
- IDLE to BUSY: start is sampled high at edge T.
  - At that edge, the result is computed from in1, in2, op and the current HI/LO, then latched into pending {phi,plo}.
  - The counter is loaded with N-1, where N is MUL_CYCLES for ops 0,1,4-7 and DIV_CYCLES for ops 2,3.
- Busy window: busy is 1 from after edge T until edge T+N, i.e. exactly N cycles.
- BUSY: the counter decrements each edge. At edge T+N (counter 0 reached):
  - hi <= phi and lo <= plo (except on divide by zero);
  - busy falls; done=1 for one cycle; state returns to IDLE.
- Back-to-back: start is accepted in the first IDLE cycle after done. There is no lost cycle.
- Arithmetic:
  - MULT/MULTU: {HI,LO} = full 2*WIDTH-bit signed/unsigned product.
  - MADD(U)/MSUB(U): {HI,LO} = {HI,LO} +/- product, computed mod 2^(2*WIDTH). {HI,LO} is sampled at launch.
  - DIV: quotient to LO, remainder to HI. Quotient truncates toward zero; remainder takes the dividend's sign.
  - DIV with most-negative / -1: LO = most-negative, HI = 0 (no trap).
  - DIVU: unsigned quotient and remainder.
  - Divide by zero (op 2/3, in2==0): full DIV_CYCLES latency. HI/LO are left unchanged; div0 pulses with done.
- MTHI/MTLO:
  - In IDLE, hiwe/lowe write in1 at the edge. Both may be asserted together.
  - hiwe/lowe are ignored while busy, and ignored in the same cycle as an accepted start (start wins).
- start while busy: ignored, with no state change. Hazard logic must never do this.
- Reset mid-operation: aborts immediately and all state returns to reset values. No commit, no done.
- Outputs hi and lo are registered. The new value is visible in the cycle done is high.

Optional Feature:
- Macro: MDU_FLUSH_EN.
- With the macro defined: adds input port flush (1 bit), used for exception/eret pipeline flush.
  - flush high at an edge while BUSY: return to IDLE, discard pending, hi/lo keep their pre-op values, no done/div0.
  - flush in IDLE suppresses start, hiwe and lowe in that cycle.
  - flush has priority over the commit edge.
- Without the macro: no flush port. Operations always run to completion.

Decomposition:
- Shared package mdu_pkg holds:
  - op encoding localparams MDU_MULT..MDU_MSUBU (3-bit);
  - state encoding MDU_IDLE/MDU_BUSY;
  - a clog2 helper for the counter width, max(MUL_CYCLES, DIV_CYCLES).
- One sub-module is natural: mdu_arith, a purely combinational unit.
  - Inputs: op, in1, in2, hi, lo.
  - Outputs: phi, plo, is_div, dz.
  - It holds all signed/unsigned multiply, accumulate and divide rules.
- The top keeps the FSM, counter and HI/LO registers.

Test Plan:
- MULT, in1=0xFFFFFFFF, in2=2 -> busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFE, done one pulse. MULTU with the same operands -> hi=0x00000001, lo=0xFFFFFFFE.
- DIV, in1=0xFFFFFFF9 (-7), in2=2 -> busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI 0x0 and MTLO 0xFFFFFFFF, then MADDU 1*1 -> hi=0x00000001, lo=0x00000000. MSUB 1*1 from {0,0} -> hi=lo=0xFFFFFFFF.
- DIVU 5/0 with hi=0x12, lo=0x34 -> busy 10 cycles; done and div0 pulse together; hi=0x12, lo=0x34 unchanged.
- Pulse start again mid-busy, and pulse hiwe mid-busy -> no effect; result and timing identical to an uninterrupted run.
- Drop reset to 0 at cycle 3 of a MULT -> busy=0, hi=lo=0 immediately, no done. With MDU_FLUSH_EN, flush at cycle 3 -> busy=0, hi/lo keep their prior values.
